// File: rtl/lca_4.sv
// lca_4: 4-bit carry-lookahead adder with registered sum and carry-out
module lca_4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic       C_1,
  output logic [3:0] S,
  output logic       CO
);
  logic [3:0] g, p, s_d, s_q;
  logic [4:0] c;
  logic       co_d, co_q;
  assign g = A_in & B_in;
  assign p = A_in ^ B_in;
  // Two-level lookahead carries: every carry is a flat sum of products of G, P and C_1.
  always_comb begin
    c[0] = C_1;
    c[1] = g[0] | (p[0] & C_1);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C_1);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & C_1);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & C_1);
    s_d  = p ^ c[3:0];
    co_d = c[4];
  end
  // Output register: one-cycle latency, cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= 4'd0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end
  assign S  = s_q;
  assign CO = co_q;
endmodule

// File: tb/tb_lca_4.sv
// tb_lca_4: self-checking bench for lca_4 against an arithmetic reference sum
module tb_lca_4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] A_in = 4'd0;
  logic [3:0] B_in = 4'd0;
  logic       C_1 = 1'b0;
  logic [3:0] S;
  logic       CO;
  int tests = 0;
  int fails = 0;

  typedef struct {
    string      name;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
  } vec_t;

  lca_4 dut (.clk(clk), .rst_n(rst_n), .A_in(A_in), .B_in(B_in), .C_1(C_1), .S(S), .CO(CO));

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_sum(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int t;
    t = int'(a) + int'(b) + int'(ci);
    return t[4:0];
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {CO,S}=%b_%h expected %b_%h", name, act[4], act[3:0], exp[4], exp[3:0]);
    end
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic ci);
    @(negedge clk);
    A_in = a;
    B_in = b;
    C_1  = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[7];
    logic [4:0] prev;
    logic [3:0] ra, rb;
    logic rc;
    vecs[0] = '{"dir_1_3_0",     4'd1,  4'd3,  1'b0, 4'd4,  1'b0};
    vecs[1] = '{"dir_11_3_1",    4'd11, 4'd3,  1'b1, 4'd15, 1'b0};
    vecs[2] = '{"dir_8_5_0",     4'd8,  4'd5,  1'b0, 4'd13, 1'b0};
    vecs[3] = '{"co_exact16",    4'd11, 4'd4,  1'b1, 4'd0,  1'b1};
    vecs[4] = '{"co_max31",      4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
    vecs[5] = '{"prop_chain_c1", 4'd15, 4'd0,  1'b1, 4'd0,  1'b1};
    vecs[6] = '{"prop_chain_c0", 4'd15, 4'd0,  1'b0, 4'd15, 1'b0};

    A_in = 4'd9; B_in = 4'd12; C_1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {CO, S}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", {CO, S}, 5'd0);
    @(posedge clk);
    #1;
    check("first_edge_load", {CO, S}, ref_sum(4'd9, 4'd12, 1'b1));

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].ci);
      check(vecs[i].name, {CO, S}, {vecs[i].co, vecs[i].s});
      check({vecs[i].name, "_model"}, {CO, S}, ref_sum(vecs[i].a, vecs[i].b, vecs[i].ci));
    end

    apply(4'd7, 4'd6, 1'b0);
    prev = {CO, S};
    A_in = 4'd2; B_in = 4'd1; C_1 = 1'b1;
    #2;
    check("mid_cycle_input_ignored", {CO, S}, ref_sum(4'd7, 4'd6, 1'b0));
    @(posedge clk);
    #1;
    check("mid_cycle_next_edge", {CO, S}, ref_sum(4'd2, 4'd1, 1'b1));

    for (int k = 0; k < 512; k++) begin
      apply(k[3:0], k[7:4], k[8]);
      check($sformatf("exh_%0d", k), {CO, S}, ref_sum(k[3:0], k[7:4], k[8]));
    end

    for (int k = 0; k < 200; k++) begin
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rc = 1'($urandom_range(1));
      apply(ra, rb, rc);
      check($sformatf("rand_%0d", k), {CO, S}, ref_sum(ra, rb, rc));
    end

    apply(4'd5, 4'd9, 1'b1);
    check("pre_reset_nonzero", {CO, S}, 5'd15);
    #2;
    rst_n = 1'b0;
    #1;
    check("midstream_async_reset", {CO, S}, 5'd0);
    @(posedge clk);
    #1;
    check("midstream_reset_hold", {CO, S}, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_reload", {CO, S}, ref_sum(4'd5, 4'd9, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lca_4.md
LCA_4 -- requirements
Module: lca_4

Interface
- REQ-001: Parameters: none; the datapath width is fixed at 4 bits.
- REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: A_in  input  4  addend A, unsigned.
- REQ-005: B_in  input  4  addend B, unsigned.
- REQ-006: C_1  input  1  carry-in to bit 0.
- REQ-007: S  output  4  registered sum, bits [3:0] of A_in+B_in+C_1.
- REQ-008: CO  output  1  registered carry-out, bit 4 of A_in+B_in+C_1.

Function
- REQ-009: The core SHALL form per-bit generate G[i]=A_in[i]&B_in[i] and propagate P[i]=A_in[i]^B_in[i], for i=0..3.
- REQ-010: Carries SHALL be computed by two-level lookahead equations from G, P and C_1 only, with no ripple chain:
  - C[0]=C_1
  - C[1]=G0|P0·C_1
  - C[2]=G1|P1·G0|P1·P0·C_1
  - C[3]=G2|P2·G1|P2·P1·G0|P2·P1·P0·C_1
  - C[4]=G3|P3·G2|P3·P2·G1|P3·P2·P1·G0|P3·P2·P1·P0·C_1
- REQ-011: The sum SHALL be sum[i]=P[i]^C[i]; the carry-out SHALL be C[4].
- REQ-012: S and CO SHALL be registered on every rising clk edge from the current A_in, B_in and C_1; latency is exactly 1 cycle and throughput is 1 result per cycle, with no handshake.
- REQ-013: {CO,S} SHALL equal A_in+B_in+C_1 as a 5-bit unsigned value for all 512 input combinations.
- REQ-014: Overflow wraps: S holds the low 4 bits and CO=1 whenever the total is 16 or more. The maximum case 15+15+1=31 SHALL give S=4'hF, CO=1.
- REQ-015: Inputs that change between clock edges SHALL have no effect on the outputs until the next rising edge.
- REQ-016: The design SHALL contain no latches and no combinational path from inputs to outputs.

Reset
- REQ-017: While rst_n=0, S SHALL be 4'd0 and CO SHALL be 0, immediately and independent of clk.
- REQ-018: Reset assertion in the middle of operation SHALL clear the outputs asynchronously.
- REQ-019: On deassertion of rst_n, the first rising clk edge SHALL load the sum of the inputs present at that edge.

Verification
- REQ-020: Reset: rst_n=0 with arbitrary inputs -> S=0, CO=0; after rst_n rises, outputs stay 0 until the first clk edge.
- REQ-021: Directed sums, each checked one cycle after being applied:
  - A=1, B=3, C_1=0 -> S=4, CO=0
  - A=11, B=3, C_1=1 -> S=15, CO=0
  - A=8, B=5, C_1=0 -> S=13, CO=0
- REQ-022: Carry-out boundaries:
  - A=11, B=4, C_1=1 -> S=0, CO=1 (total exactly 16)
  - A=15, B=15, C_1=1 -> S=15, CO=1
- REQ-023: Full propagate chain: A=15, B=0, C_1=1 -> S=0, CO=1. The same inputs with C_1=0 -> S=15, CO=0.
- REQ-024: Exhaustive check: drive all 512 combinations back-to-back, one per cycle, and compare {CO,S} against the reference sum with 1-cycle latency.
- REQ-025: Mid-stream reset: assert rst_n=0 between clk edges while S is nonzero -> outputs go to 0 without a clock edge.
